fft_butterfly_r2: RTL and testbench

- Radix-2 DIT butterfly engine. Sits directly downstream of FFT stage 3.
- Consumes one operand pair (a, b) plus twiddle W per valid_in pulse.
- Produces X0 = a + W·b and X1 = a − W·b in Q1.15, with optional per-stage ÷2 scaling and saturation.
- Tracks pairs per frame and flags the last pair and any in-frame saturation for the next stage and the control FSM.

---
 rtl/fft_butterfly_r2_if.sv | 41 ++++
 rtl/fft_butterfly_r2.sv | 161 ++++++++++++++++
 tb/tb_fft_butterfly_r2.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_butterfly_r2_if.sv
// Operand/result bundle for the radix-2 butterfly.
// slave  : the butterfly (consumes a, b, W; produces X0, X1, status).
// master : the upstream stage / bench driving operands and observing results.
// Signals: valid_in, data_in_{real,imag}_{0,1}, coeff_in_{real,imag},
//          valid_out, data_out_{real,imag}_{0,1}, sat_out, frame_done, frame_ovf.
interface fft_butterfly_r2_if #(
   parameter int Q_IN    = 15,
   parameter int Q_COEFF = 15,
   parameter int Q_OUT   = 15
);
   logic                    valid_in;
   logic signed [Q_IN:0]    data_in_real_0;
   logic signed [Q_IN:0]    data_in_imag_0;
   logic signed [Q_IN:0]    data_in_real_1;
   logic signed [Q_IN:0]    data_in_imag_1;
   logic signed [Q_COEFF:0] coeff_in_real;
   logic signed [Q_COEFF:0] coeff_in_imag;

   logic                    valid_out;
   logic signed [Q_OUT:0]   data_out_real_0;
   logic signed [Q_OUT:0]   data_out_imag_0;
   logic signed [Q_OUT:0]   data_out_real_1;
   logic signed [Q_OUT:0]   data_out_imag_1;
   logic                    sat_out;
   logic                    frame_done;
   logic                    frame_ovf;

   modport slave (
      input  valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
             coeff_in_real, coeff_in_imag,
      output valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1,
             sat_out, frame_done, frame_ovf
   );

   modport master (
      output valid_in, data_in_real_0, data_in_imag_0, data_in_real_1, data_in_imag_1,
             coeff_in_real, coeff_in_imag,
      input  valid_out, data_out_real_0, data_out_imag_0, data_out_real_1, data_out_imag_1,
             sat_out, frame_done, frame_ovf
   );
endinterface

// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly: X0 = a + W*b, X1 = a - W*b, Q1.15 fixed point,
// optional /2 rounding per stage, saturation, and per-frame pair tracking.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bf    - operand/result bundle (slave side), see fft_butterfly_r2_if
// Latency: four register stages (input, multiply, round, add/sub/saturate).
module fft_butterfly_r2 #(
   parameter int Q_IN    = 15,
   parameter int Q_COEFF = 15,
   parameter int Q_OUT   = 15,
   parameter int N       = 256,
   parameter int SCALE   = 1
) (
   input  logic              clk,
   input  logic              reset,
   fft_butterfly_r2_if.slave bf
);
   localparam int WI    = Q_IN + 1;
   localparam int WC    = Q_COEFF + 1;
   localparam int WP    = 2 * WC;
   localparam int WT    = Q_IN + 3;
   localparam int WS    = Q_IN + 4;
   localparam int WO    = Q_OUT + 1;
   localparam int PAIRS = N / 2;
   localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

   localparam logic signed [WP:0]    RND   = (WP+1)'(1 <<< (Q_COEFF - 1));
   localparam logic signed [WS-1:0]  ONE_S = WS'(1);
   localparam logic signed [WS-1:0]  MAX_S = WS'((1 <<< Q_OUT) - 1);
   localparam logic signed [WS-1:0]  MIN_S = WS'(-(1 <<< Q_OUT));
   localparam logic [CNT_W-1:0]      LAST  = CNT_W'(PAIRS - 1);

   logic                   v1_q, v2_q, v3_q, vo_q;
   logic signed [WI-1:0]   ar1_q, ai1_q, br1_q, bi1_q;
   logic signed [WC-1:0]   cr1_q, ci1_q;
   logic signed [WP-1:0]   pr_q, pi_q, qr_q, qi_q;
   logic signed [WI-1:0]   ar2_q, ai2_q, ar3_q, ai3_q;
   logic signed [WT-1:0]   tr_q, ti_q;
   logic signed [WO-1:0]   xr0_q, xi0_q, xr1_q, xi1_q;
   logic                   sat_q, done_q, ovf_q, acc_q;
   logic [CNT_W-1:0]       cnt_q;

   logic signed [WP-1:0]   pr_d, pi_d, qr_d, qi_d;
   logic signed [WP:0]     tr_full, ti_full;
   logic signed [WT-1:0]   tr_d, ti_d;
   logic signed [WS-1:0]   s0r_d, s0i_d, s1r_d, s1i_d;
   logic                   sat_any_d, last_d;

   function automatic logic signed [WS-1:0] scale_fn(input logic signed [WS-1:0] x);
      if (SCALE != 0) return (x + ONE_S) >>> 1;
      else            return x;
   endfunction

   function automatic logic is_ovf(input logic signed [WS-1:0] x);
      return (x > MAX_S) || (x < MIN_S);
   endfunction

   function automatic logic signed [WO-1:0] clip(input logic signed [WS-1:0] x);
      if (x > MAX_S)      return WO'(MAX_S);
      else if (x < MIN_S) return WO'(MIN_S);
      else                return WO'(x);
   endfunction

   // Operands widened before multiplying so -1 * -1 (= +2^30) fits.
   assign pr_d = WP'(cr1_q) * WP'(br1_q);
   assign pi_d = WP'(ci1_q) * WP'(bi1_q);
   assign qr_d = WP'(cr1_q) * WP'(bi1_q);
   assign qi_d = WP'(ci1_q) * WP'(br1_q);

   // One guard bit for the combine, then round half up back to data scale.
   assign tr_full = (WP+1)'(pr_q) - (WP+1)'(pi_q) + RND;
   assign ti_full = (WP+1)'(qr_q) + (WP+1)'(qi_q) + RND;
   assign tr_d    = WT'(tr_full >>> Q_COEFF);
   assign ti_d    = WT'(ti_full >>> Q_COEFF);

   always_comb begin
      s0r_d = scale_fn(WS'(ar3_q) + WS'(tr_q));
      s0i_d = scale_fn(WS'(ai3_q) + WS'(ti_q));
      s1r_d = scale_fn(WS'(ar3_q) - WS'(tr_q));
      s1i_d = scale_fn(WS'(ai3_q) - WS'(ti_q));
   end

   assign sat_any_d = is_ovf(s0r_d) | is_ovf(s0i_d) | is_ovf(s1r_d) | is_ovf(s1i_d);
   assign last_d    = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q  <= 1'b0;  v2_q  <= 1'b0;  v3_q  <= 1'b0;  vo_q  <= 1'b0;
         ar1_q <= '0;    ai1_q <= '0;    br1_q <= '0;    bi1_q <= '0;
         cr1_q <= '0;    ci1_q <= '0;
         pr_q  <= '0;    pi_q  <= '0;    qr_q  <= '0;    qi_q  <= '0;
         ar2_q <= '0;    ai2_q <= '0;    ar3_q <= '0;    ai3_q <= '0;
         tr_q  <= '0;    ti_q  <= '0;
         xr0_q <= '0;    xi0_q <= '0;    xr1_q <= '0;    xi1_q <= '0;
         sat_q <= 1'b0;  done_q <= 1'b0; ovf_q <= 1'b0;  acc_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         v1_q <= bf.valid_in;
         v2_q <= v1_q;
         v3_q <= v2_q;
         vo_q <= v3_q;

         if (bf.valid_in) begin
            ar1_q <= bf.data_in_real_0;
            ai1_q <= bf.data_in_imag_0;
            br1_q <= bf.data_in_real_1;
            bi1_q <= bf.data_in_imag_1;
            cr1_q <= bf.coeff_in_real;
            ci1_q <= bf.coeff_in_imag;
         end

         if (v1_q) begin
            pr_q  <= pr_d;
            pi_q  <= pi_d;
            qr_q  <= qr_d;
            qi_q  <= qi_d;
            ar2_q <= ar1_q;
            ai2_q <= ai1_q;
         end

         if (v2_q) begin
            tr_q  <= tr_d;
            ti_q  <= ti_d;
            ar3_q <= ar2_q;
            ai3_q <= ai2_q;
         end

         if (v3_q) begin
            xr0_q  <= clip(s0r_d);
            xi0_q  <= clip(s0i_d);
            xr1_q  <= clip(s1r_d);
            xi1_q  <= clip(s1i_d);
            sat_q  <= sat_any_d;
            done_q <= last_d;
            ovf_q  <= last_d & (acc_q | sat_any_d);
            if (last_d) begin
               cnt_q <= '0;
               acc_q <= 1'b0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
               acc_q <= acc_q | sat_any_d;
            end
         end else begin
            // Status flags are pulses; data outputs hold between pairs.
            sat_q  <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
         end
      end
   end

   assign bf.valid_out       = vo_q;
   assign bf.data_out_real_0 = xr0_q;
   assign bf.data_out_imag_0 = xi0_q;
   assign bf.data_out_real_1 = xr1_q;
   assign bf.data_out_imag_1 = xi1_q;
   assign bf.sat_out         = sat_q;
   assign bf.frame_done      = done_q;
   assign bf.frame_ovf       = ovf_q;
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Directed bench for fft_butterfly_r2: an unscaled and a scaled instance
// receive identical operands; results are compared with hand-derived values.
module tb_fft_butterfly_r2;
   logic clk;
   logic reset;
   int   vectors;
   int   errors;

   fft_butterfly_r2_if #(.Q_IN(15), .Q_COEFF(15), .Q_OUT(15)) if0 ();
   fft_butterfly_r2_if #(.Q_IN(15), .Q_COEFF(15), .Q_OUT(15)) if1 ();

   fft_butterfly_r2 #(.Q_IN(15), .Q_COEFF(15), .Q_OUT(15), .N(256), .SCALE(0)) dut0 (
      .clk(clk), .reset(reset), .bf(if0)
   );
   fft_butterfly_r2 #(.Q_IN(15), .Q_COEFF(15), .Q_OUT(15), .N(256), .SCALE(1)) dut1 (
      .clk(clk), .reset(reset), .bf(if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input int ar, input int ai, input int br, input int bi, input int cr, input int ci);
      if0.valid_in = 1'b1;        if1.valid_in = 1'b1;
      if0.data_in_real_0 = 16'(ar); if1.data_in_real_0 = 16'(ar);
      if0.data_in_imag_0 = 16'(ai); if1.data_in_imag_0 = 16'(ai);
      if0.data_in_real_1 = 16'(br); if1.data_in_real_1 = 16'(br);
      if0.data_in_imag_1 = 16'(bi); if1.data_in_imag_1 = 16'(bi);
      if0.coeff_in_real  = 16'(cr); if1.coeff_in_real  = 16'(cr);
      if0.coeff_in_imag  = 16'(ci); if1.coeff_in_imag  = 16'(ci);
   endtask

   task automatic idle();
      if0.valid_in = 1'b0;
      if1.valid_in = 1'b0;
   endtask

   // Called right after drive(); drops valid_in after one edge and waits
   // (bounded) for the result, checking the latency in edges.
   task automatic await_out(input string tag);
      int lat;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) idle();
      end while (!if0.valid_out && lat < 10);
      chk({tag, "_lat"}, lat, 4);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      int hold_r;
      logic exp_v;

      vectors = 0;
      errors  = 0;
      reset   = 1'b1;
      idle();
      drive(0, 0, 0, 0, 0, 0);
      idle();
      repeat (3) tick();
      reset = 1'b0;

      chk("rst_vo",   if0.valid_out, 0);
      chk("rst_x0r",  if0.data_out_real_0, 0);
      chk("rst_x0i",  if0.data_out_imag_0, 0);
      chk("rst_x1r",  if0.data_out_real_1, 0);
      chk("rst_x1i",  if0.data_out_imag_1, 0);
      chk("rst_sat",  if0.sat_out, 0);
      chk("rst_done", if0.frame_done, 0);
      chk("rst_ovf",  if0.frame_ovf, 0);

      // W = 1 (0x7FFF): t = 2000
      drive(1000, 0, 2000, 0, 32767, 0);
      await_out("v1");
      chk("v1_x0r", if0.data_out_real_0, 3000);
      chk("v1_x0i", if0.data_out_imag_0, 0);
      chk("v1_x1r", if0.data_out_real_1, -1000);
      chk("v1_x1i", if0.data_out_imag_1, 0);
      chk("v1_sat", if0.sat_out, 0);
      chk("v1s_vo",  if1.valid_out, 1);
      chk("v1s_x0r", if1.data_out_real_0, 1500);
      chk("v1s_x1r", if1.data_out_real_1, -500);
      chk("v1s_x1i", if1.data_out_imag_1, 0);
      tick();
      chk("v1_vo_low", if0.valid_out, 0);
      chk("v1_hold",   if0.data_out_real_0, 3000);
      chk("v1_sat_low", if0.sat_out, 0);

      // W = -j: t = (0, -2000)
      drive(1000, 0, 2000, 0, 0, -32768);
      await_out("v2");
      chk("v2_x0r", if0.data_out_real_0, 1000);
      chk("v2_x0i", if0.data_out_imag_0, -2000);
      chk("v2_x1r", if0.data_out_real_1, 1000);
      chk("v2_x1i", if0.data_out_imag_1, 2000);
      chk("v2s_x0r", if1.data_out_real_0, 500);
      chk("v2s_x0i", if1.data_out_imag_0, -1000);
      chk("v2s_x1i", if1.data_out_imag_1, 1000);

      // Positive overflow: t = 32766, s0 = 65533
      drive(32767, 0, 32767, 0, 32767, 0);
      await_out("v3");
      chk("v3_x0r", if0.data_out_real_0, 32767);
      chk("v3_x1r", if0.data_out_real_1, 1);
      chk("v3_sat", if0.sat_out, 1);
      chk("v3s_x0r", if1.data_out_real_0, 32767);
      chk("v3s_x1r", if1.data_out_real_1, 1);
      chk("v3s_sat", if1.sat_out, 0);

      // Negative overflow on X1 only
      drive(-32768, 0, 32767, 0, 32767, 0);
      await_out("v4");
      chk("v4_x0r", if0.data_out_real_0, -2);
      chk("v4_x1r", if0.data_out_real_1, -32768);
      chk("v4_sat", if0.sat_out, 1);
      chk("v4s_x0r", if1.data_out_real_0, -1);
      chk("v4s_x1r", if1.data_out_real_1, -32767);
      chk("v4s_sat", if1.sat_out, 0);

      // W = -1, b = -1: product +2^30, t = 32768
      drive(0, 0, -32768, 0, -32768, 0);
      await_out("v5");
      chk("v5_x0r", if0.data_out_real_0, 32767);
      chk("v5_x1r", if0.data_out_real_1, -32768);
      chk("v5_x0i", if0.data_out_imag_0, 0);
      chk("v5_sat", if0.sat_out, 1);
      chk("v5s_x0r", if1.data_out_real_0, 16384);
      chk("v5s_x1r", if1.data_out_real_1, -16384);
      chk("v5s_sat", if1.sat_out, 0);

      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Two back-to-back frames, full throughput; pair 57 saturates.
      p = 0;
      for (int c = 0; c < 266; c++) begin
         if (c < 256) begin
            if (c == 57) drive(32767, 0, 32767, 0, 32767, 0);
            else         drive(100, 0, 100, 0, 32767, 0);
         end else begin
            idle();
         end
         tick();
         if (if0.valid_out) begin
            chk("st_done", if0.frame_done, (p == 127 || p == 255));
            chk("st_ovf",  if0.frame_ovf,  (p == 127));
            chk("st_sat",  if0.sat_out,    (p == 57));
            chk("st_x0r",  if0.data_out_real_0, (p == 57) ? 32767 : 200);
            p++;
         end
      end
      chk("st_pulses", p, 256);

      // Upstream cadence: a pair every 3 cycles.
      hold_r = 200;
      for (int c = 0; c < 16; c++) begin
         if (c == 0 || c == 3 || c == 6) drive(100 * (c + 1), -50, 2000, 0, 32767, 0);
         else                             idle();
         tick();
         exp_v = (c == 3 || c == 6 || c == 9);
         chk("sp_vo", if0.valid_out, exp_v);
         if (exp_v) hold_r = 100 * (c - 2) + 2000;
         chk("sp_x0r", if0.data_out_real_0, hold_r);
         if (exp_v) chk("sp_x1i", if0.data_out_imag_1, -50);
      end

      // Reset two cycles after valid_in discards the pair.
      drive(1234, 0, 2000, 0, 32767, 0);
      tick();
      idle();
      tick();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("rm_vo", if0.valid_out, 0);
      end
      chk("rm_x0r",  if0.data_out_real_0, 0);
      chk("rm_x1r",  if0.data_out_real_1, 0);
      chk("rm_done", if0.frame_done, 0);

      // Pair counter restarted: done on the 128th post-reset pair.
      p = 0;
      for (int c = 0; c < 136; c++) begin
         if (c < 128) drive(100, 0, 100, 0, 32767, 0);
         else         idle();
         tick();
         if (if0.valid_out) begin
            chk("pr_done", if0.frame_done, (p == 127));
            chk("pr_ovf",  if0.frame_ovf, 0);
            p++;
         end
      end
      chk("pr_pulses", p, 128);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
